// File: rtl/serial_adc_scanner.sv
// serial_adc_scanner: frame sequencer and channel scanner for TLC2543-class serial ADCs.
// Optional build macro AD_EOC_WAIT_EN: end the conversion wait early on a synchronised AD_EOC rise.
module serial_adc_scanner #(
    parameter int DATA_W  = 10,
    parameter int ADDR_W  = 4,
    parameter int NUM_CH  = 4,
    parameter int CLK_DIV = 13,
    parameter int TSU_CS  = 72,
    parameter int TCONV   = 1051
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              scan_en,
    input  logic              mode,
    input  logic [ADDR_W-1:0] single_ch,
    input  logic              AD_EOC,
    input  logic              AD_DigData_In,
    output logic              AD_CSn,
    output logic              AD_Clk,
    output logic              AD_Address,
    output logic [DATA_W-1:0] sample_data,
    output logic [ADDR_W-1:0] sample_ch,
    output logic              sample_valid,
    output logic              busy
);
    localparam int MAXA = (TSU_CS > CLK_DIV) ? TSU_CS : CLK_DIV;
    localparam int MAXC = (TCONV > MAXA) ? TCONV : MAXA;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int BW   = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        IDLE, CS_SETUP, CLK_LO, CLK_HI, CS_REL, CONV
    } state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [BW-1:0]     bit_idx, bit_idx_nx, bit_inc;
    logic [ADDR_W-1:0] cur_addr, cur_addr_nx;
    logic [ADDR_W-1:0] prev_addr, prev_addr_nx;
    logic [ADDR_W-1:0] scan_ptr, scan_ptr_nx;
    logic [ADDR_W-1:0] start_addr, addr_sh;
    logic              cur_mode, cur_mode_nx;
    logic              prev_valid, prev_valid_nx;
    logic [DATA_W-1:0] shreg, shreg_nx;
    logic [DATA_W-1:0] data_nx;
    logic [ADDR_W-1:0] ch_nx;
    logic              csn_nx, adclk_nx, adaddr_nx, valid_nx;
    logic              conv_done;

    assign start_addr = mode ? single_ch : scan_ptr;

`ifdef AD_EOC_WAIT_EN
    logic eoc_s1, eoc_s2, eoc_s3;

    // Two-flop synchroniser for AD_EOC plus one history flop for rise detection.
    always_ff @(posedge CLK) begin
        if (RST) begin
            eoc_s1 <= 1'b0;
            eoc_s2 <= 1'b0;
            eoc_s3 <= 1'b0;
        end else begin
            eoc_s1 <= AD_EOC;
            eoc_s2 <= eoc_s1;
            eoc_s3 <= eoc_s2;
        end
    end

    assign conv_done = (cnt == CW'(TCONV)) ||
                       (eoc_s2 && !eoc_s3 && (cnt >= CW'(8)));
`else
    logic unused_eoc;
    assign unused_eoc = AD_EOC;
    assign conv_done  = (cnt == CW'(TCONV));
`endif

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt + 1'b1;
        bit_idx_nx    = bit_idx;
        bit_inc       = bit_idx + 1'b1;
        cur_addr_nx   = cur_addr;
        cur_mode_nx   = cur_mode;
        prev_addr_nx  = prev_addr;
        prev_valid_nx = prev_valid;
        scan_ptr_nx   = scan_ptr;
        shreg_nx      = shreg;
        csn_nx        = AD_CSn;
        adclk_nx      = AD_Clk;
        adaddr_nx     = AD_Address;
        data_nx       = sample_data;
        ch_nx         = sample_ch;
        valid_nx      = 1'b0;
        addr_sh       = '0;
        unique case (state)
            IDLE: begin
                cnt_nx = '0;
                if (scan_en) begin
                    state_nx    = CS_SETUP;
                    csn_nx      = 1'b0;
                    cur_mode_nx = mode;
                    cur_addr_nx = start_addr;
                end
            end
            CS_SETUP: begin
                if (cnt == CW'(TSU_CS - 1)) begin
                    state_nx   = CLK_LO;
                    cnt_nx     = '0;
                    bit_idx_nx = '0;
                    addr_sh    = cur_addr;
                    adaddr_nx  = addr_sh[ADDR_W-1];
                end
            end
            CLK_LO: begin
                if (cnt == CW'(CLK_DIV - 1)) begin
                    state_nx = CLK_HI;
                    cnt_nx   = '0;
                    adclk_nx = 1'b1;
                    shreg_nx = DATA_W'({shreg, AD_DigData_In});
                end
            end
            CLK_HI: begin
                if (cnt == CW'(CLK_DIV - 1)) begin
                    cnt_nx     = '0;
                    adclk_nx   = 1'b0;
                    bit_idx_nx = bit_inc;
                    if (bit_inc == BW'(DATA_W)) begin
                        state_nx  = CS_REL;
                        adaddr_nx = 1'b0;
                    end else begin
                        state_nx  = CLK_LO;
                        // Bits past the address width shift out as zero.
                        addr_sh   = cur_addr << bit_inc;
                        adaddr_nx = addr_sh[ADDR_W-1];
                    end
                end
            end
            CS_REL: begin
                state_nx = CONV;
                cnt_nx   = '0;
                csn_nx   = 1'b1;
                // Data of this frame belongs to the previous frame's address.
                if (prev_valid) begin
                    data_nx  = shreg;
                    ch_nx    = prev_addr;
                    valid_nx = 1'b1;
                end
                prev_addr_nx  = cur_addr;
                prev_valid_nx = 1'b1;
                if (!cur_mode) begin
                    scan_ptr_nx = (scan_ptr == ADDR_W'(NUM_CH - 1)) ?
                                  '0 : scan_ptr + 1'b1;
                end
            end
            CONV: begin
                // The exit cycle is part of the CS-high time (TCONV + 1).
                if (conv_done) begin
                    cnt_nx = '0;
                    if (scan_en) begin
                        state_nx    = CS_SETUP;
                        csn_nx      = 1'b0;
                        cur_mode_nx = mode;
                        cur_addr_nx = start_addr;
                    end else begin
                        state_nx      = IDLE;
                        prev_valid_nx = 1'b0;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            cur_addr     <= '0;
            cur_mode     <= 1'b0;
            prev_addr    <= '0;
            prev_valid   <= 1'b0;
            scan_ptr     <= '0;
            shreg        <= '0;
            AD_CSn       <= 1'b1;
            AD_Clk       <= 1'b0;
            AD_Address   <= 1'b0;
            sample_data  <= '0;
            sample_ch    <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            bit_idx      <= bit_idx_nx;
            cur_addr     <= cur_addr_nx;
            cur_mode     <= cur_mode_nx;
            prev_addr    <= prev_addr_nx;
            prev_valid   <= prev_valid_nx;
            scan_ptr     <= scan_ptr_nx;
            shreg        <= shreg_nx;
            AD_CSn       <= csn_nx;
            AD_Clk       <= adclk_nx;
            AD_Address   <= adaddr_nx;
            sample_data  <= data_nx;
            sample_ch    <= ch_nx;
            sample_valid <= valid_nx;
            busy         <= (state_nx != IDLE);
        end
    end
endmodule

// File: tb/tb_serial_adc_scanner.sv
// tb_serial_adc_scanner: random-stimulus bench with a behavioural ADC,
// an expectation queue and an independent strobe monitor.
module tb_serial_adc_scanner;
    localparam int DATA_W  = 10;
    localparam int ADDR_W  = 4;
    localparam int NUM_CH  = 3;
    localparam int CLK_DIV = 13;
    localparam int TSU_CS  = 72;
    localparam int TCONV   = 1051;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              scan_en = 1'b0;
    logic              mode = 1'b0;
    logic [ADDR_W-1:0] single_ch = '0;
    logic              AD_EOC = 1'b0;
    logic              AD_DigData_In = 1'b0;
    logic              AD_CSn, AD_Clk, AD_Address;
    logic [DATA_W-1:0] sample_data;
    logic [ADDR_W-1:0] sample_ch;
    logic              sample_valid, busy;

    serial_adc_scanner #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH),
        .CLK_DIV(CLK_DIV), .TSU_CS(TSU_CS), .TCONV(TCONV)
    ) dut (
        .CLK(CLK), .RST(RST), .scan_en(scan_en), .mode(mode),
        .single_ch(single_ch), .AD_EOC(AD_EOC),
        .AD_DigData_In(AD_DigData_In), .AD_CSn(AD_CSn),
        .AD_Clk(AD_Clk), .AD_Address(AD_Address),
        .sample_data(sample_data), .sample_ch(sample_ch),
        .sample_valid(sample_valid), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Inputs as the DUT saw them at the most recent edge.
    logic              edge_mode;
    logic [ADDR_W-1:0] edge_ch;
    always @(posedge CLK) begin
        edge_mode <= mode;
        edge_ch   <= single_ch;
    end

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] ch;
    } exp_t;
    exp_t sb[$];

    logic [DATA_W-1:0] chan_val [16];
    logic [DATA_W-1:0] adc_result, out_word;
    logic [ADDR_W-1:0] exp_addr, prev_exp, rx_addr;
    int  exp_ptr = 0;
    int  rises = 0;
    int  frames = 0;
    int  bitpos = 0;
    int  t_fall = 0, t_last = 0, t_csr = 0;
    bit  cs_q = 1'b1, clk_q = 1'b0;
    bit  have_prev = 1'b0, hi_chk = 1'b0;
    bit  restart = 1'b0, eoc_frame = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    task automatic check_range(input string name, input int act,
                               input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_frames(input int n);
        int target;
        int budget;
        target = frames + n;
        budget = 2000 * n;
        while (frames < target && budget > 0) begin
            @(negedge CLK);
            budget--;
        end
        if (frames < target) check("frame_timeout", frames, target);
    endtask

    task automatic wait_rises(input int n);
        int budget;
        budget = 600;
        while (rises < n && budget > 0) begin
            @(negedge CLK);
            budget--;
        end
        if (rises < n) check("rise_timeout", rises, n);
    endtask

    task automatic wait_idle();
        int budget;
        budget = 3000;
        while (busy && budget > 0) begin
            @(negedge CLK);
            budget--;
        end
        check("idle_reached", busy, 0);
    endtask

    // Behavioural TLC-style ADC: shifts out the previous conversion, captures the new address.
    initial begin
        adc_result = DATA_W'($urandom);
        forever begin
            @(negedge CLK);
            if (RST) begin
                cs_q = 1'b1;
                clk_q = 1'b0;
                rises = 0;
                have_prev = 1'b0;
                hi_chk = 1'b0;
                restart = 1'b0;
                exp_ptr = 0;
                sb.delete();
            end else begin
                if (cs_q && !AD_CSn) begin
                    exp_addr = edge_mode ? edge_ch : ADDR_W'(exp_ptr);
                    if (!edge_mode) exp_ptr = (exp_ptr + 1) % NUM_CH;
                    if (restart) begin
                        have_prev = 1'b0;
                        hi_chk = 1'b0;
                        restart = 1'b0;
                    end
                    if (hi_chk) begin
                        if (eoc_frame) begin
`ifdef AD_EOC_WAIT_EN
                            check_range("cs_high_eoc", cyc - t_csr, 200, 208);
`else
                            check("cs_high_eoc_ignored", cyc - t_csr, TCONV + 1);
`endif
                            eoc_frame = 1'b0;
                        end else begin
                            check("cs_high", cyc - t_csr, TCONV + 1);
                        end
                    end
                    hi_chk = 1'b0;
                    t_fall = cyc;
                    rises = 0;
                    rx_addr = '0;
                    out_word = adc_result;
                    AD_DigData_In = out_word[DATA_W-1];
                    bitpos = 1;
                    frames++;
                end
                if (!clk_q && AD_Clk) begin
                    rises++;
                    if (rises == 1) check("cs_to_first_clk", cyc - t_fall, TSU_CS + CLK_DIV);
                    else check("clk_period", cyc - t_last, 2 * CLK_DIV);
                    t_last = cyc;
                    if (rises <= ADDR_W) rx_addr = {rx_addr[ADDR_W-2:0], AD_Address};
                    else check("addr_tail_zero", AD_Address, 0);
                    if (rises == DATA_W && have_prev) sb.push_back('{out_word, prev_exp});
                end
                if (clk_q && !AD_Clk && bitpos < DATA_W) begin
                    AD_DigData_In = out_word[DATA_W-1-bitpos];
                    bitpos++;
                end
                if (!cs_q && AD_CSn) begin
                    check("clk_rises_per_frame", rises, DATA_W);
                    check("last_clk_to_cs", cyc - t_last, CLK_DIV + 1);
                    check("addr_sent", rx_addr, exp_addr);
                    adc_result = chan_val[rx_addr];
                    prev_exp = exp_addr;
                    have_prev = 1'b1;
                    t_csr = cyc;
                    hi_chk = 1'b1;
                end
                cs_q = AD_CSn;
                clk_q = AD_Clk;
            end
        end
    end

    // Strobe monitor: every sample_valid consumes one queued expectation.
    initial begin
        exp_t e;
        bit   csq;
        csq = 1'b1;
        forever begin
            @(negedge CLK);
            if (sample_valid) begin
                check("strobe_on_cs_rise", {30'd0, csq, AD_CSn}, 1);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got ch %0d data 0x%0h, expected no strobe",
                             sample_ch, sample_data);
                end else begin
                    e = sb.pop_front();
                    check("sample_data", sample_data, e.data);
                    check("sample_ch", sample_ch, e.ch);
                end
            end
            csq = AD_CSn;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got no finish, expected finish before 80000 cycles");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) chan_val[i] = DATA_W'($urandom);
        chan_val[5] = 10'h2A5;
        RST = 1'b1;
        scan_en = 1'b1;
        mode = 1'b1;
        single_ch = 4'd5;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_csn", AD_CSn, 1);
        check("rst_clk", AD_Clk, 0);
        check("rst_addr", AD_Address, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_data", sample_data, 0);
        check("rst_ch", sample_ch, 0);
        step();
        RST = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("first_frame_csn", AD_CSn, 0);
        check("first_frame_busy", busy, 1);

        wait_frames(4);

        mode = 1'b0;
        for (int i = 0; i < NUM_CH; i++) chan_val[i] = DATA_W'($urandom);
        wait_frames(6);

        wait_rises(5);
        step();
        scan_en = 1'b0;
        wait_idle();
        repeat ($urandom_range(20, 100)) step();
        @(negedge CLK);
        check("idle_csn_high", AD_CSn, 1);
        check("idle_busy", busy, 0);

        restart = 1'b1;
        mode = 1'($urandom);
        single_ch = ADDR_W'($urandom);
        step();
        scan_en = 1'b1;
        for (int f = 0; f < 4; f++) begin
            wait_frames(1);
            wait_rises($urandom_range(1, 9));
            step();
            mode = 1'($urandom);
            single_ch = ADDR_W'($urandom);
            chan_val[$urandom_range(0, 15)] = DATA_W'($urandom);
        end

        wait_frames(1);
        wait_rises(5);
        step();
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("midrst_csn", AD_CSn, 1);
        check("midrst_clk", AD_Clk, 0);
        check("midrst_valid", sample_valid, 0);
        check("midrst_busy", busy, 0);
        step();
        RST = 1'b0;
        mode = 1'b0;
        wait_frames(3);

        wait_rises(DATA_W);
        while (!AD_CSn) @(negedge CLK);
        eoc_frame = 1'b1;
        repeat (200) step();
        AD_EOC = 1'b1;
        repeat (4) step();
        AD_EOC = 1'b0;
        wait_frames(2);

        step();
        scan_en = 1'b0;
        wait_idle();
        repeat (5) step();
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
